// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: PDM mic clock gen, mono/stereo capture, boxcar decimation to PCM, output FIFO
module pdm_mic_rx #(
  parameter int CLK_DIV    = 50,
  parameter int DECIM      = 64,
  parameter int OUT_W      = 16,
  parameter int CHANNELS   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             MIC_CLK,
  input  logic             MIC_DATA,
  output logic             MIC_LR_SEL,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_chan,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overflow,
  input  logic             clr_ovf
);
  localparam int LD = $clog2(DECIM);
  localparam int DW = $clog2(CLK_DIV);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int SH = OUT_W - 1 - LD;
  localparam int EW = OUT_W + 1;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic          mic_q, mic_d;
  logic          seen_q, seen_d;
  logic [LD:0]   ones_q [2];
  logic [LD:0]   ones_d [2];
  logic [LD:0]   fin [2];
  logic [LD-1:0] bit_q [2];
  logic [LD-1:0] bit_d [2];
  logic [1:0]    samp, close;
  logic          pend_q, pend_d;
  logic [EW-1:0] pend_e_q, pend_e_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [FA-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FA:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          tick, pop, full, push;

  // 2*ones - DECIM scaled to full scale; only ones == DECIM can exceed the positive range
  function automatic logic [OUT_W-1:0] conv(input logic [LD:0] o);
    logic [OUT_W-1:0] diff;
    diff = OUT_W'({o, 1'b0}) - OUT_W'(DECIM);
    return (o == (LD+1)'(DECIM)) ? {1'b0, {(OUT_W-1){1'b1}}} : diff << SH;
  endfunction

  assign tick    = en && (div_q == DW'(CLK_DIV - 1));
  assign samp[0] = tick && mic_q;
  assign samp[1] = tick && !mic_q && seen_q && (CHANNELS == 2);

  // Divider and MIC_CLK; right sampling arms only after the first left bit so left leads each pair
  always_comb begin
    div_d  = (!en || tick) ? '0 : div_q + DW'(1);
    mic_d  = en && (mic_q ^ tick);
    seen_d = en && (seen_q || samp[0]);
  end

  // Per-channel ones/bit counters; a closing window restarts both counters at the next bit
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      fin[c]   = ones_q[c] + (LD+1)'(sync2_q);
      close[c] = samp[c] && (bit_q[c] == LD'(DECIM - 1));
      ones_d[c] = (!en || close[c]) ? '0 : samp[c] ? fin[c] : ones_q[c];
      bit_d[c]  = (!en || close[c]) ? '0 : samp[c] ? bit_q[c] + LD'(1) : bit_q[c];
    end
    pend_d   = |close;
    pend_e_d = close[1] ? {1'b1, conv(fin[1])} : close[0] ? {1'b0, conv(fin[0])} : pend_e_q;
  end

  assign pop  = (cnt_q != '0) && pcm_ready;
  assign full = cnt_q == (FA+1)'(FIFO_DEPTH);
  assign push = pend_q && (!full || pop);

  // FIFO pointers, storage and sticky overflow; a new drop outranks clr_ovf
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = pend_e_q;
    wr_d  = wr_q + FA'(push);
    rd_d  = rd_q + FA'(pop);
    cnt_d = cnt_q + (FA+1)'(push) - (FA+1)'(pop);
    ovf_d = (pend_q && full && !pop) || (ovf_q && !clr_ovf);
  end

  // All state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      div_q    <= '0;
      mic_q    <= 1'b0;
      seen_q   <= 1'b0;
      ones_q   <= '{default: '0};
      bit_q    <= '{default: '0};
      pend_q   <= 1'b0;
      pend_e_q <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= MIC_DATA;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      mic_q    <= mic_d;
      seen_q   <= seen_d;
      ones_q   <= ones_d;
      bit_q    <= bit_d;
      pend_q   <= pend_d;
      pend_e_q <= pend_e_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign MIC_CLK              = mic_q;
  assign MIC_LR_SEL           = 1'b0;
  assign {pcm_chan, pcm_data} = mem_q[rd_q];
  assign pcm_valid            = cnt_q != '0;
  assign overflow             = ovf_q;
endmodule

// File: tb/tb_pdm_mic_rx.sv
// tb_pdm_mic_rx: directed checks of a mono and a stereo pdm_mic_rx sharing one mic line
module tb_pdm_mic_rx;
  localparam int OW = 12;
  localparam logic [OW:0] SAT  = 13'h07FF;
  localparam logic [OW:0] NEG  = 13'h0800;
  localparam logic [OW:0] RNEG = 13'h1800;

  logic clk = 0, rst = 1, en = 0, m_ready = 0, clr = 0, alt = 0;
  logic s_ready = 1;
  int mode = 1, cyc = 0, checks = 0, errors = 0;
  logic mic_data;
  logic m_clk, m_lr, m_chan, m_valid, m_ovf;
  logic s_clk, s_lr, s_chan, s_valid, s_ovf;
  logic [OW-1:0] m_data, s_data;
  logic [OW:0] mq[$], sq[$];
  int mt[$];

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(16), .OUT_W(OW), .CHANNELS(1), .FIFO_DEPTH(4)) u_mono (
    .clk(clk), .rst(rst), .en(en), .MIC_CLK(m_clk), .MIC_DATA(mic_data), .MIC_LR_SEL(m_lr),
    .pcm_data(m_data), .pcm_chan(m_chan), .pcm_valid(m_valid), .pcm_ready(m_ready),
    .overflow(m_ovf), .clr_ovf(clr));

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(16), .OUT_W(OW), .CHANNELS(2), .FIFO_DEPTH(4)) u_st (
    .clk(clk), .rst(rst), .en(en), .MIC_CLK(s_clk), .MIC_DATA(mic_data), .MIC_LR_SEL(s_lr),
    .pcm_data(s_data), .pcm_chan(s_chan), .pcm_valid(s_valid), .pcm_ready(s_ready),
    .overflow(s_ovf), .clr_ovf(clr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge s_clk) alt <= ~alt;
  assign mic_data = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? alt : s_clk;

  always @(negedge clk) begin
    #1;
    if (m_valid && m_ready) begin
      mq.push_back({m_chan, m_data});
      mt.push_back(cyc);
    end
    if (s_valid && s_ready) sq.push_back({s_chan, s_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart(input int m, input logic rdy);
    en = 0;
    m_ready = 1;
    repeat (4) @(negedge clk);
    mode = m;
    repeat (4) @(negedge clk);
    mq.delete();
    mt.delete();
    sq.delete();
    m_ready = rdy;
    en = 1;
  endtask

  initial begin
    #2 rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_mic_clk", m_clk, 0);
    chk("rst_lr_sel", m_lr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_chan", m_chan, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_ovf", m_ovf, 0);
    rst = 1;
    repeat (2) @(negedge clk);

    restart(1, 0);
    repeat (128) @(negedge clk);
    chk("valid_at_T", m_valid, 0);
    @(negedge clk);
    chk("valid_at_T2", m_valid, 1);
    chk("ones_sat", m_data, 12'h7FF);
    chk("mono_chan", m_chan, 0);
    chk("lr_sel_run", m_lr, 0);
    m_ready = 1;
    repeat (300) @(negedge clk);
    chk("mono_count", mq.size(), 3);
    for (int i = 0; i < 3; i++) chk("mono_sat_seq", mq[i], SAT);
    chk("mono_spacing1", mt[1] - mt[0], 128);
    chk("mono_spacing2", mt[2] - mt[1], 128);

    restart(0, 1);
    repeat (260) @(negedge clk);
    chk("zeros_count", mq.size(), 2);
    chk("zeros_s0", mq[0], NEG);
    chk("zeros_s1", mq[1], NEG);

    restart(2, 1);
    repeat (260) @(negedge clk);
    chk("alt_count", mq.size(), 2);
    chk("alt_s0", mq[0], 0);
    chk("alt_s1", mq[1], 0);

    restart(3, 1);
    repeat (270) @(negedge clk);
    chk("st_count", sq.size(), 4);
    chk("st_l0", sq[0], SAT);
    chk("st_r0", sq[1], RNEG);
    chk("st_l1", sq[2], SAT);
    chk("st_r1", sq[3], RNEG);

    restart(1, 0);
    repeat (640) @(negedge clk);
    chk("ovf_before_drop", m_ovf, 0);
    chk("full_valid", m_valid, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("drop_beats_clr", m_ovf, 1);
    en = 0;
    m_ready = 1;
    repeat (10) @(negedge clk);
    chk("drain_count", mq.size(), 4);
    for (int i = 0; i < 4; i++) chk("drain_seq", mq[i], SAT);
    chk("drain_empty", m_valid, 0);
    chk("ovf_sticky", m_ovf, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("ovf_cleared", m_ovf, 0);

    restart(1, 1);
    repeat (82) @(negedge clk);
    en = 0;
    @(negedge clk);
    chk("mic_low_en0_a", m_clk, 0);
    repeat (3) @(negedge clk);
    chk("mic_low_en0_b", m_clk, 0);
    chk("partial_none", mq.size(), 0);
    mode = 0;
    repeat (4) @(negedge clk);
    en = 1;
    repeat (128) @(negedge clk);
    chk("fresh_not_early", mq.size(), 0);
    repeat (2) @(negedge clk);
    chk("fresh_count", mq.size(), 1);
    chk("fresh_value", mq[0], NEG);

    restart(1, 0);
    repeat (131) @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    rst = 0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_chan", m_chan, 0);
    chk("arst_ovf", m_ovf, 0);
    chk("arst_mic_clk", m_clk, 0);
    en = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    m_ready = 1;
    repeat (20) @(negedge clk);
    chk("no_stale_pop", mq.size(), 0);
    chk("no_stale_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

Parametrised PDM microphone receiver for the FIR audio platform. It generates the microphone clock, captures mono or stereo PDM bit streams, and decimates them with a boxcar ones-counter into signed PCM samples. The samples pass through a small output FIFO with a valid/ready handshake. It sits between the board microphone pins and the record buffer that feeds the FIR cores, replacing a fixed-rate mono capture path with one configurable in clock rate, decimation, sample width and channel count.

## Interface
- CLK_DIV, 50, system clocks per MIC_CLK half-period (≥4); 100 MHz clk gives a 1 MHz MIC_CLK
- DECIM, 64, PDM bits per PCM sample per channel; power of two, 4..1024
- OUT_W, 16, PCM sample width; must be > log2(DECIM)
- CHANNELS, 1, 1 = mono (left only), 2 = stereo (left + right)
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  capture enable
- MIC_CLK  out  1  PDM clock to the microphone(s)
- MIC_DATA  in  1  PDM data; asynchronous to clk
- MIC_LR_SEL  out  1  constant 0; in stereo the second mic is strapped for right
- pcm_data  out  OUT_W  signed PCM sample at the FIFO head
- pcm_chan  out  1  0 = left, 1 = right; always 0 when CHANNELS=1
- pcm_valid  out  1  FIFO non-empty
- pcm_ready  in  1  consumer accepts the head sample when valid && ready
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Reset: MIC_CLK=0, MIC_LR_SEL=0, pcm_data=0, pcm_chan=0, pcm_valid=0, overflow=0. The divider, bit counters, ones counters and FIFO are empty.
- MIC_DATA passes through a 2-flop synchroniser. "Sampled bit" below means the synchroniser output.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. At the clock where div_cnt==CLK_DIV-1, MIC_CLK toggles and div_cnt wraps to 0.
- Left bit is sampled on the clk edge where MIC_CLK falls. Right bit (CHANNELS=2) is sampled on the edge where MIC_CLK rises. Right sampling is disabled when CHANNELS=1.
- Per channel, ones_cnt (log2(DECIM)+1 bits) accumulates sampled 1s and bit_cnt counts bits. At the DECIM-th bit, the window closes and both counters restart at the next bit; no bits are lost.
- Conversion: diff = 2·ones − DECIM, in the range [−DECIM, +DECIM]. The sample is diff << (OUT_W−1−log2(DECIM)). A result of +2^(OUT_W−1) saturates to 2^(OUT_W−1)−1; the negative extreme is exact.
- The converted sample and its channel tag are pushed to the FIFO. If the FIFO is full and no pop happens in the same cycle, the sample is dropped and overflow is set. A push and pop in the same cycle on a full FIFO is accepted.
- overflow stays set until clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- en 1→0: MIC_CLK is forced to 0 next cycle; the divider and all counters clear; any partial window is discarded. FIFO contents remain and can be drained.
- en 0→1: capture starts with a fresh window; the first MIC_CLK rise comes CLK_DIV cycles later.

## Timing
- MIC_CLK period = 2·CLK_DIV clk cycles with 50% duty.
- Output sample rate per channel = f_clk / (2·CLK_DIV·DECIM).
- A window closes on edge T. Its push happens at T+1 and pcm_valid is high from T+2 if the FIFO was empty.
- Pop takes effect on the edge where valid && ready. The next entry is visible the cycle after.
- pcm_data and pcm_chan hold stable while valid && !ready.
- Left and right windows close half a MIC_CLK period apart, so they are never pushed in the same cycle.
- Reset asserted mid-window or mid-handshake clears everything asynchronously, with no partial sample emitted afterwards.

## Test plan
- Mono, DECIM=64, OUT_W=16, MIC_DATA constant 1, pcm_ready=1 → every sample is 0x7FFF (saturated), pcm_chan=0, one sample per 6400 clk.
- MIC_DATA constant 0 → 0x8000. An alternating 1/0 pattern on left samples → 0x0000.
- CHANNELS=2 with left bits 1 and right bits 0 (toggle MIC_DATA with MIC_CLK) → alternating samples 0x7FFF/chan0 and 0x8000/chan1, left first.
- pcm_ready=0 for 5 windows with FIFO_DEPTH=4 → 4 samples held, overflow=1 after the 5th window. Raise ready → exactly 4 pops in order. Pulse clr_ovf → overflow=0.
- Drop en in mid-window after 30 ones, then re-enable → no sample from the partial window; the next sample reflects only the new 64 bits. MIC_CLK stays low while en=0.
- Assert rst low mid-handshake with valid=1 → all outputs are at reset values immediately. After release, no stale sample appears.
